write_control_param: RTL and testbench
======================================

Name: write_control_param

Overview:
- Parametrised write-side control block for the FIFO; successor to the fixed-width write controller.
- Generates the binary write pointer and memory write enable, as before.
- Adds a registered Gray-coded pointer for clock-domain crossing, locally computed full/almost-full flags from a synchronised read pointer, a write-side occupancy count and a sticky overflow flag.
- Sits in the wr_clk domain between the producer, the dual-port RAM write port and the read-pointer synchroniser.

Parameters:
- A_LENGTH, 4: RAM address width; DEPTH = 2**A_LENGTH; pointers are A_LENGTH+1 bits. Legal range A_LENGTH >= 2.
- AF_THRESH, 2: almost-full asserts when free slots <= AF_THRESH. Legal range 0 <= AF_THRESH < DEPTH.

Ports:
- wr_clk  in  1  write-domain clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable_wr  in  1  producer write request.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- rd_ptr_gray_sync  in  A_LENGTH+1  Gray read pointer, already synchronised into wr_clk.
- enable_wr_out  out  1  RAM write enable; also the pointer increment qualifier.
- wr_ptr  out  A_LENGTH+1  binary write pointer.
- b_wr_ptr  out  A_LENGTH  RAM write address, equal to wr_ptr[A_LENGTH-1:0].
- MSB_wr_ptr  out  1  wr_ptr[A_LENGTH], the wrap bit.
- wr_ptr_gray  out  A_LENGTH+1  registered Gray form of wr_ptr, sent to the read-domain synchroniser.
- f_full  out  1  registered full flag.
- f_almost_full  out  1  registered almost-full flag.
- wr_level  out  A_LENGTH+1  registered occupancy as seen from the write side, range 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (asynchronous, immediate, also when asserted mid-operation): wr_ptr=0, wr_ptr_gray=0, f_full=0, f_almost_full=0, wr_level=0, overflow=0. Consequently enable_wr_out=enable_wr.
- enable_wr_out = enable_wr & ~f_full. Combinational, so zero latency from enable_wr.
- Pointer update:
  - wr_ptr_next = wr_ptr + enable_wr_out, modulo 2**(A_LENGTH+1).
  - On wrap from all-ones to 0, MSB_wr_ptr toggles.
- Gray pointer: wr_ptr_gray <= wr_ptr_next ^ (wr_ptr_next >> 1). It is registered in the same cycle as wr_ptr, so it is always the Gray image of wr_ptr and changes by exactly one bit per write.
- Level and flags:
  - rd_bin = Gray-to-binary of rd_ptr_gray_sync (combinational).
  - level_next = (wr_ptr_next - rd_bin) modulo 2**(A_LENGTH+1).
  - Every clock: wr_level <= level_next; f_full <= (level_next == DEPTH); f_almost_full <= (level_next >= DEPTH - AF_THRESH).
  - Flags re-evaluate every cycle, so a read-pointer advance releases full one cycle after rd_ptr_gray_sync changes, with no write needed.
  - A stale read pointer only makes full pessimistic, never optimistic.
- Full boundary:
  - The write that brings level to DEPTH is accepted; f_full is 1 from the next cycle.
  - While f_full=1, wr_ptr and wr_ptr_gray hold.
- Overflow:
  - Set on any edge where enable_wr & f_full.
  - Cleared by clr_ovf only.
  - If clr_ovf and a new overflow occur in the same cycle, set wins.
- Illegal input: if rd_ptr_gray_sync implies the read pointer is ahead of the write pointer, level wraps modulo. This is not detected; it is a read-side responsibility.
- All outputs are registered except enable_wr_out, b_wr_ptr and MSB_wr_ptr, which are slices or gates of registers.

Decomposition:
- Shared header/package:
  - default A_LENGTH;
  - derived DEPTH;
  - bin2gray and gray2bin functions, reused by the read-side successor.
- One natural sub-module: gray_to_binary, a parametrised A_LENGTH+1 XOR-prefix converter, also instantiated on the read side.
- The binary counter stays inline; the parametrised increment is trivial.

Test Plan (A_LENGTH=4, DEPTH=16, AF_THRESH=2):
- Reset: after 5 writes, assert reset between clock edges → all registered outputs go to 0 immediately without a clock edge; enable_wr_out follows enable_wr.
- Fill: rd_ptr_gray_sync=0, 16 consecutive writes →
  - f_almost_full=1 after the 14th write (wr_level=14);
  - f_full=1 after the 16th write, with wr_ptr=5'b10000, wr_ptr_gray=5'b11000;
  - enable_wr_out=0.
- Overflow: at full, hold enable_wr=1 for 3 cycles → wr_ptr stays 16, overflow=1 the next cycle. Then pulse clr_ovf with enable_wr=0 → overflow=0.
- Release: at full, drive rd_ptr_gray_sync=5'b00001 (binary 1) → next cycle f_full=0, wr_level=15, f_almost_full=1. A write is then accepted.
- Wrap: rd_ptr_gray_sync tracks wr_ptr_gray minus 4 entries; write 40 times → wr_ptr counts 31→0, MSB_wr_ptr toggles, wr_ptr_gray goes 5'b10000→5'b00000, wr_level constant at 4, f_full never asserts.
- Simultaneous: at full with overflow=1, assert clr_ovf and enable_wr in the same cycle → overflow remains 1.

Source files
------------

// File: rtl/write_control_param_pkg.sv
// Shared definitions for the FIFO write-side and read-side pointer logic.
// Holds the default address width, the depth derived from it and the Gray-code helpers.
// Both helpers work on 32-bit zero-extended values, so callers cast to/from their pointer width.
package write_control_param_pkg;

  localparam int A_LENGTH_DEF = 4;
  localparam int DEPTH_DEF    = 2 ** A_LENGTH_DEF;

  // Binary to Gray: adjacent codes differ in exactly one bit.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/write_control_param_if.sv
// Write-side FIFO control bundle between the producer and the write controller.
// Ports: producer request/clear and synchronised read pointer in; RAM enable/address,
//        binary and Gray write pointers, full/almost-full flags, level and overflow out.
interface write_control_param_if #(
  parameter int A_LENGTH = write_control_param_pkg::A_LENGTH_DEF
);
  logic                enable_wr;
  logic                clr_ovf;
  logic [A_LENGTH:0]   rd_ptr_gray_sync;
  logic                enable_wr_out;
  logic [A_LENGTH:0]   wr_ptr;
  logic [A_LENGTH-1:0] b_wr_ptr;
  logic                MSB_wr_ptr;
  logic [A_LENGTH:0]   wr_ptr_gray;
  logic                f_full;
  logic                f_almost_full;
  logic [A_LENGTH:0]   wr_level;
  logic                overflow;

  // Producer side.
  modport master (
    output enable_wr, clr_ovf, rd_ptr_gray_sync,
    input  enable_wr_out, wr_ptr, b_wr_ptr, MSB_wr_ptr, wr_ptr_gray,
           f_full, f_almost_full, wr_level, overflow
  );

  // Write controller side.
  modport slave (
    input  enable_wr, clr_ovf, rd_ptr_gray_sync,
    output enable_wr_out, wr_ptr, b_wr_ptr, MSB_wr_ptr, wr_ptr_gray,
           f_full, f_almost_full, wr_level, overflow
  );
endinterface

// File: rtl/write_control_param_gray_to_binary.sv
// Parametrised Gray-to-binary converter (XOR prefix from the MSB down), shared with the read side.
// Ports: gray_i (W bits) in, bin_o (W bits) out.
// Purely combinational; no clock, no latency.
module write_control_param_gray_to_binary #(
  parameter int W = write_control_param_pkg::A_LENGTH_DEF + 1
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o        = '0;
    bin_o[W-1]   = gray_i[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/write_control_param.sv
// Write-side FIFO control: binary/Gray write pointers, RAM write enable, full/almost-full,
// write-side occupancy and sticky overflow, all in the wr_clk domain.
// Ports: wr_clk, reset (async, active-high) and the slave side of write_control_param_if.
module write_control_param
  import write_control_param_pkg::*;
#(
  parameter int A_LENGTH  = A_LENGTH_DEF,
  parameter int AF_THRESH = 2
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  write_control_param_if.slave  wif
);

  localparam int PTR_W = A_LENGTH + 1;
  localparam int DEPTH = 2 ** A_LENGTH;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] rd_bin;
  logic             wr_acc;

  write_control_param_gray_to_binary #(.W(PTR_W)) u_rd_g2b (
    .gray_i (wif.rd_ptr_gray_sync),
    .bin_o  (rd_bin)
  );

  // A write is accepted only while not full; this also qualifies the pointer increment.
  assign wr_acc = wif.enable_wr & ~full_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_acc);
    wr_gray_d = PTR_W'(bin2gray(32'(wr_ptr_d)));
    // Modulo subtraction; an out-of-range read pointer simply wraps the level.
    level_d   = wr_ptr_d - rd_bin;
    full_d    = (level_d == PTR_W'(DEPTH));
    afull_d   = (level_d >= PTR_W'(DEPTH - AF_THRESH));
    // A new overflow takes priority over a clear in the same cycle.
    if (wif.enable_wr && full_q) begin
      ovf_d = 1'b1;
    end else if (wif.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wif.enable_wr_out = wr_acc;
  assign wif.wr_ptr        = wr_ptr_q;
  assign wif.b_wr_ptr      = wr_ptr_q[A_LENGTH-1:0];
  assign wif.MSB_wr_ptr    = wr_ptr_q[A_LENGTH];
  assign wif.wr_ptr_gray   = wr_gray_q;
  assign wif.f_full        = full_q;
  assign wif.f_almost_full = afull_q;
  assign wif.wr_level      = level_q;
  assign wif.overflow      = ovf_q;

endmodule

// File: tb/tb_write_control_param.sv
// Testbench for write_control_param with A_LENGTH=4, AF_THRESH=2.
// Table of stimulus/expected records, scoreboard queue between drive and check,
// plus a hand-written asynchronous reset sequence.
module tb_write_control_param;

  typedef struct {
    string      name;
    logic       we;
    logic       clr;
    logic [4:0] rdg;
    logic       exp_ewo;
    logic [4:0] exp_ptr;
    logic [4:0] exp_gray;
    logic [4:0] exp_lvl;
    logic       exp_full;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  write_control_param_if #(.A_LENGTH(4)) wif ();

  write_control_param #(.A_LENGTH(4), .AF_THRESH(2)) dut (
    .wr_clk (clk),
    .reset  (rst),
    .wif    (wif)
  );

  function automatic logic [4:0] g(input logic [4:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(input string nm, input logic we, input logic clr,
                              input logic [4:0] rd_bin, input logic ewo,
                              input logic [4:0] ptr, input logic [4:0] lvl,
                              input logic full, input logic af, input logic ovf);
    vec_t v;
    v.name = nm; v.we = we; v.clr = clr; v.rdg = g(rd_bin);
    v.exp_ewo = ewo; v.exp_ptr = ptr; v.exp_gray = g(ptr); v.exp_lvl = lvl;
    v.exp_full = full; v.exp_af = af; v.exp_ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string nm, input vec_t e);
    chk({nm, ".wr_ptr"},   32'(wif.wr_ptr),        32'(e.exp_ptr));
    chk({nm, ".b_ptr"},    32'(wif.b_wr_ptr),      32'(e.exp_ptr[3:0]));
    chk({nm, ".msb"},      32'(wif.MSB_wr_ptr),    32'(e.exp_ptr[4]));
    chk({nm, ".gray"},     32'(wif.wr_ptr_gray),   32'(e.exp_gray));
    chk({nm, ".level"},    32'(wif.wr_level),      32'(e.exp_lvl));
    chk({nm, ".full"},     32'(wif.f_full),        32'(e.exp_full));
    chk({nm, ".afull"},    32'(wif.f_almost_full), 32'(e.exp_af));
    chk({nm, ".overflow"}, 32'(wif.overflow),      32'(e.exp_ovf));
  endtask

  // Drive on the falling edge, check the combinational enable, queue the expected
  // registered state, then pop and compare it just after the rising edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    wif.enable_wr        = v.we;
    wif.clr_ovf          = v.clr;
    wif.rd_ptr_gray_sync = v.rdg;
    #1;
    chk({v.name, ".ewo"}, 32'(wif.enable_wr_out), 32'(v.exp_ewo));
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", v.name);
    end else begin
      e = sb.pop_front();
      check_regs(e.name, e);
    end
  endtask

  initial begin
    vec_t z;
    logic [4:0] p;
    wif.enable_wr = 1'b0;
    wif.clr_ovf = 1'b0;
    wif.rd_ptr_gray_sync = '0;

    // Reset state while reset is held from time zero.
    #2;
    z = mk("rst0", 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check_regs("rst0", z);
    @(negedge clk);
    rst = 1'b0;

    // Five writes, then an asynchronous reset between clock edges.
    for (int k = 1; k <= 5; k++)
      apply(mk("pre", 1'b1, 1'b0, 5'd0, 1'b1, 5'(k), 5'(k), 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_regs("rst_mid", z);
    chk("rst_mid.ewo_hi", 32'(wif.enable_wr_out), 32'd1);
    wif.enable_wr = 1'b0;
    #1;
    chk("rst_mid.ewo_lo", 32'(wif.enable_wr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill from empty: almost-full at level 14, full at 16.
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk("fill", 1'b1, 1'b0, 5'd0, 1'b1, 5'(k), 5'(k),
                       (k == 16), (k >= 14), 1'b0));
    // Writes while full: blocked, overflow set on the first.
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk("ovf", 1'b1, 1'b0, 5'd0, 1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk("clr", 1'b0, 1'b1, 5'd0, 1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b0));
    // Overflow again, then set and clear in the same cycle: set wins.
    tbl.push_back(mk("ovf2", 1'b1, 1'b0, 5'd0, 1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk("simul", 1'b1, 1'b1, 5'd0, 1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk("clr2", 1'b0, 1'b1, 5'd0, 1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b0));
    // Read pointer advances by one: full releases without a write, then a write fills again.
    tbl.push_back(mk("rel", 1'b0, 1'b0, 5'd1, 1'b0, 5'd16, 5'd15, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk("rel_wr", 1'b1, 1'b0, 5'd1, 1'b1, 5'd17, 5'd16, 1'b1, 1'b1, 1'b0));
    // Read pointer jumps to leave four entries, then 40 writes across the pointer wrap.
    tbl.push_back(mk("wrap0", 1'b0, 1'b0, 5'd13, 1'b0, 5'd17, 5'd4, 1'b0, 1'b0, 1'b0));
    p = 5'd17;
    for (int k = 0; k < 40; k++) begin
      tbl.push_back(mk("wrap", 1'b1, 1'b0, 5'(p - 5'd3), 1'b1, 5'(p + 5'd1), 5'd4,
                       1'b0, 1'b0, 1'b0));
      p = p + 5'd1;
    end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (i == 15) begin
        chk("fill16.ptr_lit",  32'(wif.wr_ptr),      32'h10);
        chk("fill16.gray_lit", 32'(wif.wr_ptr_gray), 32'h18);
      end
    end

    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
